// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: FSM state encodings, RRESP codes and default widths.
package axi_ic_pkg;

   localparam int LEN_W_DEF  = 8;
   localparam int ID_W_DEF   = 4;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_RST  = 3'b111,
      ST_IDLE = 3'b000,
      ST_DATA = 3'b010,
      ST_ERRD = 3'b100,
      ST_DONE = 3'b011
   } state_e;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [1:0] RRESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_rd_beat_cnt.sv
// Read beat counter: cleared at the AR handshake, counts R beats, flags the final beat of the burst.
module axi_rd_beat_cnt
   import axi_ic_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [LEN_W-1:0] len,
   output logic [LEN_W-1:0] cnt,
   output logic             is_last
);

   logic [LEN_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt     = cnt_q;
   assign is_last = (cnt_q == len);

endmodule

// File: rtl/axi_rd_txn_fsm.sv
// Single-outstanding AXI read transaction tracker with built-in DECERR default slave.
// Optional RLAST/length consistency check enabled by defining AXI_RD_RLAST_CHK_EN.
module axi_rd_txn_fsm
   import axi_ic_pkg::*;
#(
   parameter int LEN_W  = LEN_W_DEF,
   parameter int ID_W   = ID_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ARVALID,
   input  logic              ARREADY,
   input  logic [LEN_W-1:0]  ARLEN,
   input  logic [ID_W-1:0]   ARID,
   input  logic              decerr,
   input  logic              RVALID,
   input  logic              RLAST,
   input  logic              RREADY,
   output logic              err_arready,
   output logic              err_rvalid,
   output logic              err_rlast,
   output logic [1:0]        err_rresp,
   output logic [ID_W-1:0]   err_rid,
   output logic [DATA_W-1:0] err_rdata,
   output logic              err_sel,
   output logic              route_en,
   output logic              busy,
   output logic              decoderrst
`ifdef AXI_RD_RLAST_CHK_EN
   ,
   output logic              rlast_err
`endif
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             cnt_clr, cnt_inc;
   logic [LEN_W-1:0] beat_cnt;
   logic             beat_last;

   logic ar_err, ar_ok, r_hs;
   assign ar_err = ARVALID && decerr;
   assign ar_ok  = ARVALID && ARREADY && !decerr;
   assign r_hs   = RVALID && RREADY;

   axi_rd_beat_cnt #(.LEN_W(LEN_W)) u_beat_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .len     (len_q),
      .cnt     (beat_cnt),
      .is_last (beat_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RST;
         len_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      id_d    = id_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         ST_RST:  state_d = ST_IDLE;
         ST_IDLE: begin
            // decerr wins over a concurrent ARREADY from whatever slave is selected
            if (ar_err) begin
               len_d   = ARLEN;
               id_d    = ARID;
               cnt_clr = 1'b1;
               state_d = ST_ERRD;
            end else if (ar_ok) begin
               len_d   = ARLEN;
               cnt_clr = 1'b1;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_hs) begin
               cnt_inc = 1'b1;
               if (RLAST)
                  state_d = ST_DONE;
            end
         end
         ST_ERRD: begin
            if (RREADY) begin
               if (beat_last)
                  state_d = ST_DONE;
               else
                  cnt_inc = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_RST;
      endcase
   end

   always_comb begin
      err_arready = 1'b0;
      err_rvalid  = 1'b0;
      err_rlast   = 1'b0;
      err_rresp   = RRESP_OKAY;
      err_rid     = '0;
      err_sel     = 1'b0;
      route_en    = 1'b0;
      busy        = 1'b0;
      decoderrst  = 1'b0;
      case (state_q)
         ST_RST:  decoderrst  = 1'b1;
         ST_IDLE: err_arready = ar_err;
         ST_DATA: begin
            route_en = 1'b1;
            busy     = 1'b1;
         end
         ST_ERRD: begin
            err_sel    = 1'b1;
            err_rvalid = 1'b1;
            err_rresp  = RRESP_DECERR;
            err_rid    = id_q;
            err_rlast  = (beat_cnt == len_q);
            busy       = 1'b1;
         end
         ST_DONE: begin
            decoderrst = 1'b1;
            busy       = 1'b1;
         end
         default: decoderrst = 1'b0;
      endcase
   end

   assign err_rdata = '0;

`ifdef AXI_RD_RLAST_CHK_EN
   logic rlast_err_q, rlast_err_d;

   // Flags RLAST arriving early or missing on the beat the burst length says is last.
   always_comb begin
      rlast_err_d = rlast_err_q;
      if ((state_q == ST_DATA) && r_hs && (RLAST != beat_last))
         rlast_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rlast_err_q <= 1'b0;
      else
         rlast_err_q <= rlast_err_d;
   end

   assign rlast_err = rlast_err_q;
`endif

endmodule
